// File: rtl/io_channel_unit_pkg.sv
// io_channel_unit_pkg: channel numbering and status bit positions shared by the I/O channel block.
package io_channel_unit_pkg;
  typedef enum logic [2:0] {
    CH_KEY    = 3'd0,
    CH_STATUS = 3'd1,
    CH_DSKY   = 3'd2,
    CH_DOUT   = 3'd3,
    CH_DIN    = 3'd4,
    CH_TIMER  = 3'd5
  } io_chan_t;
  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_DSKY     = 3;
  localparam int ST_DROP     = 4;
endpackage

// File: rtl/io_channel_unit_key_fifo.sv
// io_channel_unit_key_fifo: synchronous keystroke FIFO with simultaneous push/pop support.
module io_channel_unit_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  // push+pop on an empty FIFO moves both pointers so the count stays 0
  assign do_push = push & (~full | pop);
  assign do_pop = pop & (~empty | push);
  assign overflow = push & full & ~pop;
  assign head = mem[rp];
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/io_channel_unit.sv
// io_channel_unit: decodes core channel selects into keystroke FIFO, status, DSKY, discretes and timer.
module io_channel_unit
  import io_channel_unit_pkg::*;
#(
  parameter int KEY_DEPTH = 4,
  parameter int PRESCALE  = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  io_read_sel,
  output logic [14:0] io_read_data,
  input  logic [2:0]  io_write_sel,
  input  logic [14:0] io_write_data,
  input  logic        io_write_en,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        dsky_valid,
  output logic [14:0] dsky_data,
  input  logic        dsky_ready,
  input  logic [14:0] discrete_in,
  output logic [14:0] discrete_out,
  output logic        key_irq,
  output logic        timer_irq
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic wr_key, wr_status, wr_dsky, wr_dout, wr_timer;
  logic key_full, key_empty, key_ovf_evt, key_ovf, dsky_drop;
  logic [4:0] key_head;
  logic xfer, accept, tick;
  logic [14:0] din_s1, din_s2, count, status;
  logic [PW-1:0] presc;
  assign wr_key = io_write_en && io_write_sel == CH_KEY;
  assign wr_status = io_write_en && io_write_sel == CH_STATUS;
  assign wr_dsky = io_write_en && io_write_sel == CH_DSKY;
  assign wr_dout = io_write_en && io_write_sel == CH_DOUT;
  assign wr_timer = io_write_en && io_write_sel == CH_TIMER;
  io_channel_unit_key_fifo #(.DEPTH(KEY_DEPTH), .WIDTH(5)) u_key_fifo (
    .clock(clock), .reset_n(reset_n), .push(key_valid), .pop(wr_key), .din(key_code),
    .full(key_full), .empty(key_empty), .overflow(key_ovf_evt), .head(key_head)
  );
  assign key_irq = ~key_empty;
  assign xfer = dsky_valid & dsky_ready;
  assign accept = wr_dsky & (~dsky_valid | xfer);
  assign tick = presc == PW'(PRESCALE - 1);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_ovf <= 1'b0;
      dsky_drop <= 1'b0;
      dsky_valid <= 1'b0;
      dsky_data <= '0;
      discrete_out <= '0;
      din_s1 <= '0;
      din_s2 <= '0;
      count <= '0;
      presc <= '0;
      timer_irq <= 1'b0;
    end else begin
      key_ovf <= key_ovf_evt | (key_ovf & ~(wr_status & io_write_data[ST_OVF]));
      dsky_drop <= (wr_dsky & dsky_valid & ~xfer) | (dsky_drop & ~(wr_status & io_write_data[ST_DROP]));
      dsky_valid <= accept | (dsky_valid & ~xfer);
      dsky_data <= accept ? io_write_data : dsky_data;
      discrete_out <= wr_dout ? io_write_data : discrete_out;
      din_s1 <= discrete_in;
      din_s2 <= din_s1;
      presc <= wr_timer || tick ? '0 : presc + 1'b1;
      count <= wr_timer ? io_write_data : tick ? count + 1'b1 : count;
      timer_irq <= ~wr_timer & tick & (count == 15'o77777);
    end
  end
  always_comb begin
    status = '0;
    status[ST_NONEMPTY] = ~key_empty;
    status[ST_FULL] = key_full;
    status[ST_OVF] = key_ovf;
    status[ST_DSKY] = dsky_valid;
    status[ST_DROP] = dsky_drop;
  end
  always_comb begin
    io_read_data = '0;
    case (io_read_sel)
      CH_KEY:    io_read_data = key_empty ? '0 : {1'b1, 9'b0, key_head};
      CH_STATUS: io_read_data = status;
      CH_DSKY:   io_read_data = dsky_data;
      CH_DOUT:   io_read_data = discrete_out;
      CH_DIN:    io_read_data = din_s2;
      CH_TIMER:  io_read_data = count;
      default:   io_read_data = '0;
    endcase
  end
endmodule

// File: doc/io_channel_unit.md
# io_channel_unit

Peripheral I/O block directly downstream of the core's channel interface. It decodes the core's 3-bit read/write channel selects into eight 15-bit channels. The channels are:
- a DSKY keystroke FIFO
- status/sticky-error flags
- a DSKY output word with a valid/ready handshake
- discrete output and input registers
- a prescaled 15-bit timer

It raises key and timer interrupt lines back toward the core.

## Interface
Parameters:
- KEY_DEPTH, 4: keystroke FIFO entries; power of two, ≥2.
- PRESCALE, 10: clock cycles per timer increment; ≥1.

Ports:
- clock  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- io_read_sel  in  3  channel read by the core.
- io_read_data  out  15  combinational read data for io_read_sel.
- io_write_sel  in  3  channel written by the core.
- io_write_data  in  15  write data.
- io_write_en  in  1  write strobe; one write per asserted cycle.
- key_valid  in  1  one-cycle keystroke strobe from the keyboard.
- key_code  in  5  keycode qualified by key_valid.
- dsky_valid  out  1  DSKY word pending.
- dsky_data  out  15  DSKY word; stable while dsky_valid is high.
- dsky_ready  in  1  DSKY accepts; transfer completes on dsky_valid & dsky_ready.
- discrete_in  in  15  asynchronous discrete inputs.
- discrete_out  out  15  discrete output register.
- key_irq  out  1  level: key FIFO non-empty.
- timer_irq  out  1  one-cycle pulse on timer wrap.

## Operation
Channel map (read / write):
- 0 KEY: read returns {bit14 = non-empty, bits13:5 = 0, bits4:0 = head keycode}, or 0 when empty. Any write pops the head; a pop on an empty FIFO is ignored.
- 1 STATUS: read returns bit0 non-empty, bit1 full, bit2 key_overflow (sticky), bit3 dsky_valid, bit4 dsky_drop (sticky), others 0. Write is write-1-to-clear on bits 2 and 4.
- 2 DSKY: read returns dsky_data. A write when dsky_valid=0, or when a transfer completes in the same cycle, loads dsky_data and sets dsky_valid. A write while dsky_valid=1 and no transfer completes is dropped and sets dsky_drop.
- 3 DOUT: read/write discrete_out.
- 4 DIN: read returns discrete_in after a 2-flop synchronizer; writes are ignored.
- 5 TIMER: read returns the count. A write loads the count and zeroes the prescaler.
- 6, 7: read 0; writes ignored.

Keystroke FIFO:
- key_valid pushes key_code.
- Push while full with no pop: keystroke is dropped and key_overflow is set.
- Push and pop in the same cycle: both occur, including when full (no overflow) and when empty (count remains 0; the new key is stored).

Timer:
- The prescaler counts 0..PRESCALE-1. At PRESCALE-1 it returns to 0 and the count increments.
- The count wraps 'o77777 → 0. timer_irq pulses in the cycle after the count becomes 0 through wrap.
- A load of 0 does not pulse timer_irq.
- A write to TIMER in the same cycle as an increment: the write wins.

Sticky bits:
- A set event and a write-1-to-clear in the same cycle: the bit stays set.

## Timing
- Reset (reset_n low at a clock edge) zeroes the FIFO pointers/count, sticky bits, dsky_valid, dsky_data, discrete_out, synchronizer flops, timer, prescaler and timer_irq.
- All outputs read 0 after reset. Reset mid-handshake drops the pending DSKY word.
- io_read_data is combinational. A read and a write to the same channel in the same cycle returns the pre-write value; the new value is visible the next cycle.
- A keystroke pushed at edge N is readable on channel 0 after edge N, and key_irq rises after edge N.
- discrete_in latency: 2 edges.
- dsky_valid drops the cycle after a completed transfer unless a new write was accepted in that cycle.

## Structure
- Shared package: io_chan_t enum (CH_KEY=0, CH_STATUS=1, CH_DSKY=2, CH_DOUT=3, CH_DIN=4, CH_TIMER=5) and status bit-index constants.
- Sub-module key_fifo: synchronous FIFO parameterized by depth and width, with push/pop/full/empty/head outputs and simultaneous push+pop support.
- The timer, handshake register, synchronizer and channel mux live in the top level.

## Test plan
- Reset, then read all 8 channels → all return 0; dsky_valid=0; key_irq=0.
- Push keys 5'd3, 5'd17, 5'd9 → ch0 reads 'o40003. After one ch0 write it reads 'o40021. After two more writes it reads 0 and key_irq drops.
- Push 5 keys with KEY_DEPTH=4 → STATUS reads 'o7 (non-empty, full, overflow). Write ch1 'o4 → STATUS reads 'o3. Push+pop while full → no overflow.
- Write ch2 'o12345 with dsky_ready=0, then write 'o54321 → dsky_data stays 'o12345 and STATUS bit4 is set. Raise dsky_ready together with a write of 'o00777 → dsky_data becomes 'o00777 and dsky_valid stays 1.
- PRESCALE=10: write ch5 'o77776 → after 10 cycles it reads 'o77777; after 10 more it reads 0 and timer_irq pulses for exactly one cycle.
- Drive discrete_in 'o52525 → ch4 reads 'o52525 after 2 edges. Write ch3 'o70707 → discrete_out and a ch3 read both return 'o70707.
